// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
//   - Requester count and encoded-index width.
//   - FSM state encoding, also exported through the top's debug port.
//   - Default hold limit and the width of the hold counter.
//   - onehot(): index-to-one-hot helper used to build the grant vector.
package arb_pkg;

  localparam int N           = 16;
  localparam int IDX_W       = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_16_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req_i   [15:0] request vector
//   ptr_i   [3:0]  highest-priority requester
//   pick_o  [3:0]  first set request at or after ptr_i, wrapping 15 -> 0
//   found_o        high when any request is set
// The request vector is rotated right by ptr_i, so bit 0 of the rotated
// vector is requester ptr_i. The lowest set bit of the rotated vector is
// then the offset from ptr_i, and adding ptr_i (mod 16) recovers the index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] pick_o,
  output logic             found_o
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[IDX_W'(i) + ptr_i];
    end
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign pick_o  = off + ptr_i;
  assign found_o = |req_i;

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter sharing one resource between 16
// requesters. Grants are registered, held until the owner signals done,
// drops its request or exceeds the hold limit, and are always followed by
// one dead cycle (RELEASE) before the next owner.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           arbitration enable; low only blocks new grants
//   req   [15:0] request vector, bit i = requester i
//   done         owner completion strobe, sampled in GRANT only
//   gnt   [15:0] registered one-hot grant
//   gnt_idx [3:0] registered encoded grant index, 0 when no grant
//   gnt_valid    high while a grant is held
//   timeout      one-cycle pulse after a forced release
//   dbg_state_o  current FSM state (arb_state_e encoding)
//   dbg_ptr_o    current round-robin priority pointer
// Handshake: a grant is offered by raising gnt_valid with gnt/gnt_idx
// stable; it ends on the cycle after done=1 or req[gnt_idx]=0 is sampled
// while gnt_valid is high, or after TIMEOUT held cycles.
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [1:0]       dbg_state_o,
  output logic [IDX_W-1:0] dbg_ptr_o
);

  arb_state_e       state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             timeout_q;
  logic [IDX_W-1:0] ptr_q;
  logic [TO_W-1:0]  cnt_q;

  logic [IDX_W-1:0] pick;
  logic             found;
  logic             rel_normal;
  logic             hit_limit;

  rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .found_o (found)
  );

  // A normal release wins over the hold limit, so a done or request drop
  // on the last allowed cycle does not raise timeout.
  assign rel_normal = done || !req[idx_q];
  assign hit_limit  = (cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en && found) begin
            gnt_q   <= onehot(pick);
            idx_q   <= pick;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_normal || hit_limit) begin
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + IDX_W'(1);
            timeout_q <= !rel_normal;
            state_q   <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = idx_q;
  assign gnt_valid   = valid_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;
  import arb_pkg::*;

  localparam int TB_TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  logic [1:0]       dbg_state;
  logic [IDX_W-1:0] dbg_ptr;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.TIMEOUT(TB_TIMEOUT), .TO_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [IDX_W-1:0] exp_q[$];
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Grant-order monitor: every new grant start must match the next queued index.
  always @(posedge clk) begin
    #1;
    if (mon_en && gnt_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("grant_order_extra", {28'd0, gnt_idx}, 32'hFFFF_FFFF);
      else chk("grant_order", {28'd0, gnt_idx}, {28'd0, exp_q.pop_front()});
    end
    prev_valid = gnt_valid;
  end

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic [N-1:0] r, input logic d);
    en = e; req = r; done = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [N-1:0] g, input logic [IDX_W-1:0] i,
                         input logic v, input logic t);
    chk({name, "_gnt"}, {16'd0, gnt}, {16'd0, g});
    chk({name, "_idx"}, {28'd0, gnt_idx}, {28'd0, i});
    chk({name, "_valid"}, {31'd0, gnt_valid}, {31'd0, v});
    chk({name, "_timeout"}, {31'd0, timeout}, {31'd0, t});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             en;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     e_gnt;
    logic [IDX_W-1:0] e_idx;
    logic             e_valid;
    logic [IDX_W-1:0] e_ptr;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [N-1:0] r, input logic d,
                              input logic [N-1:0] g, input logic [IDX_W-1:0] i,
                              input logic v, input logic [IDX_W-1:0] p);
    vec_t x;
    x.en = e; x.req = r; x.done = d; x.e_gnt = g; x.e_idx = i; x.e_valid = v; x.e_ptr = p;
    return x;
  endfunction

  vec_t vecs[24];
  int   vt;

  initial begin
    // Inputs applied during one cycle -> outputs expected after that edge.
    vecs[0]  = mk(1, 16'h0001, 0, 16'h0001, 4'd0,  1, 4'd0);  // first grant, 1-cycle latency
    vecs[1]  = mk(1, 16'h0001, 1, 16'h0000, 4'd0,  0, 4'd1);  // done -> RELEASE, ptr=1
    vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 4'd0,  0, 4'd1);  // IDLE
    vecs[3]  = mk(1, 16'h8000, 0, 16'h8000, 4'd15, 1, 4'd1);  // grant 15
    vecs[4]  = mk(1, 16'h8000, 1, 16'h0000, 4'd0,  0, 4'd0);  // ptr wraps 15 -> 0
    vecs[5]  = mk(0, 16'h0000, 0, 16'h0000, 4'd0,  0, 4'd0);
    vecs[6]  = mk(1, 16'h8081, 0, 16'h0001, 4'd0,  1, 4'd0);  // 8081 sequence: 0
    vecs[7]  = mk(1, 16'h8081, 1, 16'h0000, 4'd0,  0, 4'd1);
    vecs[8]  = mk(1, 16'h8081, 0, 16'h0000, 4'd0,  0, 4'd1);
    vecs[9]  = mk(1, 16'h8081, 0, 16'h0080, 4'd7,  1, 4'd1);  // 7
    vecs[10] = mk(1, 16'h8081, 1, 16'h0000, 4'd0,  0, 4'd8);
    vecs[11] = mk(1, 16'h8081, 0, 16'h0000, 4'd0,  0, 4'd8);
    vecs[12] = mk(1, 16'h8081, 0, 16'h8000, 4'd15, 1, 4'd8);  // 15
    vecs[13] = mk(1, 16'h8081, 1, 16'h0000, 4'd0,  0, 4'd0);
    vecs[14] = mk(1, 16'h8081, 0, 16'h0000, 4'd0,  0, 4'd0);
    vecs[15] = mk(1, 16'h8081, 0, 16'h0001, 4'd0,  1, 4'd0);  // 0 again
    vecs[16] = mk(1, 16'h8081, 1, 16'h0000, 4'd0,  0, 4'd1);
    vecs[17] = mk(0, 16'hFFFF, 0, 16'h0000, 4'd0,  0, 4'd1);  // en=0 blocks grants
    vecs[18] = mk(0, 16'hFFFF, 0, 16'h0000, 4'd0,  0, 4'd1);
    vecs[19] = mk(0, 16'hFFFF, 0, 16'h0000, 4'd0,  0, 4'd1);
    vecs[20] = mk(0, 16'hFFFF, 1, 16'h0000, 4'd0,  0, 4'd1);  // done in IDLE ignored
    vecs[21] = mk(1, 16'h0001, 0, 16'h0001, 4'd0,  1, 4'd1);  // search wraps from ptr=1 to 0
    vecs[22] = mk(1, 16'h0001, 1, 16'h0000, 4'd0,  0, 4'd1);
    vecs[23] = mk(0, 16'h0000, 0, 16'h0000, 4'd0,  0, 4'd1);
  end

  // ---------------- test ----------------
  initial begin
    int v_cnt;
    int t_cnt;
    rst_n = 1'b0;
    drive(0, 16'h0000, 0);
    step();
    step();
    chk_out("reset", 16'h0000, 4'd0, 0, 0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("reset_ptr", {28'd0, dbg_ptr}, 32'd0);
    rst_n = 1'b1;

    // Table phase with grant-order scoreboard.
    exp_q = '{4'd0, 4'd15, 4'd0, 4'd7, 4'd15, 4'd0, 4'd0};
    mon_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].done);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_idx, vecs[i].e_valid, 1'b0);
      chk($sformatf("vec%0d_ptr", i), {28'd0, dbg_ptr}, {28'd0, vecs[i].e_ptr});
    end
    mon_en = 1'b0;
    chk("grant_order_drained", exp_q.size(), 32'd0);

    // Timeout: owner 5 holds with done=0; hold limit 4 cycles.
    v_cnt = 0;
    t_cnt = 0;
    drive(1, 16'h0020, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) drive(0, 16'h0000, 0);
      step();
      if (gnt_valid) begin
        v_cnt++;
        chk("to_idx", {28'd0, gnt_idx}, 32'd5);
      end
      if (timeout) t_cnt++;
      if (i == 4) chk("to_pulse_cycle", {31'd0, timeout}, 32'd1);
    end
    chk("to_valid_cycles", v_cnt, 32'd4);
    chk("to_pulse_count", t_cnt, 32'd1);
    chk("to_ptr", {28'd0, dbg_ptr}, 32'd6);
    chk("to_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // done on the last allowed cycle: normal release, no timeout pulse.
    drive(1, 16'h0040, 0);
    step();
    chk_out("dt_grant", 16'h0040, 4'd6, 1, 0);
    step();
    step();
    step();
    chk("dt_still_valid", {31'd0, gnt_valid}, 32'd1);
    drive(1, 16'h0040, 1);
    step();
    chk_out("dt_release", 16'h0000, 4'd0, 0, 0);
    chk("dt_ptr", {28'd0, dbg_ptr}, 32'd7);
    drive(0, 16'h0000, 0);
    step();
    chk("dt_no_late_pulse", {31'd0, timeout}, 32'd0);

    // Owner 3 drops its request while 9 requests.
    drive(1, 16'h0008, 0);
    step();
    chk_out("drop_grant3", 16'h0008, 4'd3, 1, 0);
    drive(1, 16'h0200, 0);
    step();
    chk_out("drop_release", 16'h0000, 4'd0, 0, 0);
    chk("drop_ptr", {28'd0, dbg_ptr}, 32'd4);
    step();
    chk_out("drop_idle", 16'h0000, 4'd0, 0, 0);
    step();
    chk_out("drop_grant9", 16'h0200, 4'd9, 1, 0);
    drive(1, 16'h0200, 1);
    step();
    chk("drop_ptr10", {28'd0, dbg_ptr}, 32'd10);
    drive(0, 16'h0000, 0);
    step();

    // en dropped during grant to 2: grant completes, no new grant.
    drive(1, 16'h0004, 0);
    step();
    chk_out("en_grant2", 16'h0004, 4'd2, 1, 0);
    drive(0, 16'hFFFF, 0);
    step();
    chk_out("en_hold", 16'h0004, 4'd2, 1, 0);
    drive(0, 16'hFFFF, 1);
    step();
    chk_out("en_release", 16'h0000, 4'd0, 0, 0);
    drive(0, 16'hFFFF, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("en_blocked%0d", i), {15'd0, gnt_valid, gnt}, 32'd0);
    end
    chk("en_ptr", {28'd0, dbg_ptr}, 32'd3);

    // Asynchronous reset during grant to 12.
    drive(1, 16'h1000, 0);
    step();
    chk_out("ar_grant12", 16'h1000, 4'd12, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 16'h0000, 4'd0, 0, 0);
    chk("ar_ptr", {28'd0, dbg_ptr}, 32'd0);
    chk("ar_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    #1;
    rst_n = 1'b1;
    drive(1, 16'h1001, 0);
    step();
    chk_out("ar_regrant0", 16'h0001, 4'd0, 1, 0);
    drive(1, 16'h1001, 1);
    step();
    chk("ar_no_timeout", {31'd0, timeout}, 32'd0);
    drive(0, 16'h0000, 0);
    step();

    vt = pass_cnt;
    $display("%0d/%0d checks passed", vt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one 16-way resource slot between 16 requesters.
- Each cycle it resolves the pending request bits into a single one-hot grant plus its 4-bit encoded index.
- It holds the grant until the owner signals done or drops its request, then rotates priority past the last winner.
- It sits in front of the 16-to-4 encode path and drives its select inputs from a registered, glitch-free grant.

Parameters:
N, 16, number of requesters (fixed at 16 for this revision)
IDX_W, 4, width of encoded grant index (log2 N)
TIMEOUT, 255, maximum cycles a grant may be held before forced release (1..2^TO_W-1)
TO_W, 8, width of hold counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; low blocks new grants only
req  input  16  request vector, bit i = requester i
done  input  1  owner completion strobe, sampled in GRANT only
gnt  output  16  registered one-hot grant, all-zero when none
gnt_idx  output  4  registered encoded index of gnt; 0 when gnt_valid low
gnt_valid  output  1  high while a grant is held
timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold counter=0. Assertion mid-grant aborts immediately with no done/timeout side effects.
- ptr (4 bits) is the highest-priority requester. The search order is ptr, ptr+1, ... wrapping 15 to 0.
- States:
  IDLE: if en=1 and req!=0, pick the first set bit in search order. Next edge: gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, counter=0, go to GRANT. Otherwise stay in IDLE with outputs 0.
  GRANT: gnt, gnt_idx and gnt_valid are stable. The counter increments each cycle. Exit on the first of:
  - done=1
  - req[gnt_idx]=0
  - counter==TIMEOUT-1, which also sets timeout=1 for the next cycle only.
  On exit go to RELEASE.
  RELEASE: gnt=0, gnt_valid=0, gnt_idx=0, ptr=gnt_idx+1 mod 16 (15 wraps to 0). Go to IDLE unconditionally. This guarantees one dead cycle between owners.
- Latency: request to grant is 1 cycle from IDLE. Back-to-back owners see 3 cycles minimum per grant (GRANT, RELEASE, IDLE).
- Simultaneous events: done and timeout condition in the same cycle count as a normal release, so timeout stays 0. done while in IDLE/RELEASE is ignored.
- en deasserted during GRANT does not abort; the grant completes normally and no new grant follows until en=1.
- Request bits other than the owner are ignored during GRANT. Requests may change at any time; only the IDLE-cycle sample matters.
- req changes and selection are combinational into registers. No output is combinational from inputs.
- Fairness: any continuously asserted requester is granted within 16 grants.

Decomposition:
- Shared package/include arb_pkg holds:
  - state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2)
  - N=16, IDX_W=4
  - default TIMEOUT
- Natural sub-module rr_pick: combinational. Inputs req[15:0] and ptr[3:0]; outputs pick[3:0] and found. Implemented as rotate-right by ptr, fixed-priority encode of the lowest set bit, then add ptr mod 16.
- The top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset, then req=16'h0001, en=1 -> next edge gnt=16'h0001, gnt_idx=0, gnt_valid=1. done pulse -> RELEASE, ptr=1.
- ptr=0, req=16'h8081 held, done asserted one cycle after each grant -> grant order idx 0, 7, 15, 0, with 3-cycle spacing between grant starts.
- Single owner idx=5 holding req with done=0 and TIMEOUT=4 -> gnt_valid high exactly 4 cycles, timeout pulse 1 cycle, ptr=6.
- Owner idx=3 drops req[3] mid-grant with req[9]=1 -> release next cycle, then grant idx 9 two cycles later.
- en=0 with req=16'hFFFF -> gnt stays 0. en dropped during an active grant to idx 2 -> grant finishes on done, then no new grant.
- rst_n low during GRANT to idx 12 -> all outputs 0 immediately (asynchronous). After release, req=16'h1001 grants idx 0 (ptr reset).
